// File: rtl/rf_pkg.sv
// Shared defaults, types and constants for the register file and its scoreboard.
package rf_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  // Address of the hardwired zero register when that option is enabled.
  localparam int ZERO_ADDR  = 0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, port B
// writeback or Flush clears it. Also provides hazard outputs and a busy count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] wbAddr,
  input  logic                  wbValid,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRd,
  input  logic                  flush,
  output logic                  issueStall,
  output logic                  busyRs,
  output logic                  busyRt,
  output logic [ADDR_WIDTH:0]   busyCount
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0]     busyReg;
  logic [NREG-1:0]     busyNext;
  logic [ADDR_WIDTH:0] countNext;
  logic                issueAccept;
  logic                issueToZero;

  assign issueToZero = (ZERO_REG != 0) && (int'(issueRd) == ZERO_ADDR);

  // A stalled issue is simply dropped; Flush also suppresses any issue.
  assign issueStall  = issueValid && busyReg[issueRd];
  assign issueAccept = issueValid && !issueStall && !flush && !issueToZero;

  // A register being cleared by port B this cycle no longer counts as a hazard.
  assign busyRs = busyReg[rs] && !(wbValid && (wbAddr == rs));
  assign busyRt = busyReg[rt] && !(wbValid && (wbAddr == rt));

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : gBusy
      // Set by accepted issue, else cleared by flush/writeback, else hold.
      always_comb begin
        busyNext[gi] = busyReg[gi];
        if (issueAccept && (int'(issueRd) == gi)) begin
          busyNext[gi] = 1'b1;
        end else if (flush || (wbValid && (int'(wbAddr) == gi))) begin
          busyNext[gi] = 1'b0;
        end
        if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin
          busyNext[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Population count of the next busy vector, so the count tracks the bits exactly.
  always_comb begin
    countNext = '0;
    for (int i = 0; i < NREG; i++) begin
      countNext = countNext + {{ADDR_WIDTH{1'b0}}, busyNext[i]};
    end
  end

  // Busy bits and count update together on every edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busyReg   <= '0;
      busyCount <= '0;
    end else begin
      busyReg   <= busyNext;
      busyCount <= countNext;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, an ALU write port (A), a
// late writeback port (B), optional bypass and zero register, and a busy scoreboard.
module reg_file_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WbAddr,
  input  logic [DATA_WIDTH-1:0] WbData,
  input  logic                  WbValid,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueRD,
  output logic                  IssueStall,
  output logic                  BusyRS,
  output logic                  BusyRT,
  output logic [ADDR_WIDTH:0]   BusyCount,
  input  logic                  Flush
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regMem [NREG];
  logic [ADDR_WIDTH-1:0] rdAddr [2];
  logic [DATA_WIDTH-1:0] rdData [2];
  logic                  writeA;
  logic                  writeB;

  assign writeA = RegWrite && !((ZERO_REG != 0) && (int'(RD) == ZERO_ADDR));
  assign writeB = WbValid  && !((ZERO_REG != 0) && (int'(WbAddr) == ZERO_ADDR));

  // Storage; port A is applied after port B so the younger op wins on a collision.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regMem[i] <= '0;
      end
    end else begin
      if (writeB) begin
        regMem[WbAddr] <= WbData;
      end
      if (writeA) begin
        regMem[RD] <= WriteData;
      end
    end
  end

  assign rdAddr[0] = RS;
  assign rdAddr[1] = RT;
  assign ReadRS    = rdData[0];
  assign ReadRT    = rdData[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gRead
      // Read mux: zero register, then port A bypass, then port B bypass, then storage.
      always_comb begin
        rdData[gi] = regMem[rdAddr[gi]];
        if ((ZERO_REG != 0) && (int'(rdAddr[gi]) == ZERO_ADDR)) begin
          rdData[gi] = '0;
        end else if ((BYPASS != 0) && RegWrite && (RD == rdAddr[gi])) begin
          rdData[gi] = WriteData;
        end else if ((BYPASS != 0) && WbValid && (WbAddr == rdAddr[gi])) begin
          rdData[gi] = WbData;
        end
      end
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) uScoreboard (
    .clk        (Clock),
    .rstN       (Reset_n),
    .rs         (RS),
    .rt         (RT),
    .wbAddr     (WbAddr),
    .wbValid    (WbValid),
    .issueValid (IssueValid),
    .issueRd    (IssueRD),
    .flush      (Flush),
    .issueStall (IssueStall),
    .busyRs     (BusyRS),
    .busyRt     (BusyRT),
    .busyCount  (BusyCount)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance share all inputs and are
// checked against hand-computed values.
module tb_reg_file_scoreboard;
  import rf_pkg::*;

  logic      Clock = 1'b0;
  logic      Reset_n;
  reg_addr_t RS, RT, RD, WbAddr, IssueRD;
  reg_data_t WriteData, WbData;
  logic      RegWrite, WbValid, IssueValid, Flush;

  reg_data_t rsA, rtA, rsB, rtB;
  logic      stallA, busyRsA, busyRtA, stallB, busyRsB, busyRtB;
  logic [ADDR_WIDTH:0] cntA, cntB;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  reg_file_scoreboard #(.BYPASS(1), .ZERO_REG(1)) dutA (
    .Clock(Clock), .Reset_n(Reset_n), .RS(RS), .RT(RT), .ReadRS(rsA), .ReadRT(rtA),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .WbAddr(WbAddr), .WbData(WbData), .WbValid(WbValid),
    .IssueValid(IssueValid), .IssueRD(IssueRD), .IssueStall(stallA),
    .BusyRS(busyRsA), .BusyRT(busyRtA), .BusyCount(cntA), .Flush(Flush)
  );

  reg_file_scoreboard #(.BYPASS(0), .ZERO_REG(1)) dutB (
    .Clock(Clock), .Reset_n(Reset_n), .RS(RS), .RT(RT), .ReadRS(rsB), .ReadRT(rtB),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .WbAddr(WbAddr), .WbData(WbData), .WbValid(WbValid),
    .IssueValid(IssueValid), .IssueRD(IssueRD), .IssueStall(stallB),
    .BusyRS(busyRsB), .BusyRT(busyRtB), .BusyCount(cntB), .Flush(Flush)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; RS = 4'd2; RT = 4'd3; RD = '0; WriteData = '0; RegWrite = 1'b0;
    WbAddr = '0; WbData = '0; WbValid = 1'b0; IssueValid = 1'b0; IssueRD = '0; Flush = 1'b0;

    // 1. Reset state
    #2;
    checkVal("rst_rs_a", rsA, 0);
    checkVal("rst_rt_a", rtA, 0);
    checkVal("rst_cnt_a", cntA, 0);
    checkVal("rst_rs_b", rsB, 0);
    #10 Reset_n = 1'b1;
    step();

    // 2. Port A writes, read back, same-cycle bypass
    RD = 4'd2; WriteData = 24'd5; RegWrite = 1'b1; step();
    RD = 4'd3; WriteData = 24'd7; step();
    RegWrite = 1'b0; #1;
    checkVal("rd_r2_a", rsA, 5);
    checkVal("rd_r3_a", rtA, 7);
    checkVal("rd_r2_b", rsB, 5);
    checkVal("rd_r3_b", rtB, 7);
    RD = 4'd2; WriteData = 24'd9; RegWrite = 1'b1; #1;
    checkVal("bypass_a", rsA, 9);
    checkVal("nobypass_b", rsB, 5);
    step();
    RegWrite = 1'b0; #1;
    checkVal("r2_after_b", rsB, 9);

    // 3. Issue R4, then port B writeback clears it
    IssueValid = 1'b1; IssueRD = 4'd4; #1;
    checkVal("iss4_stall", stallA, 0);
    step();
    IssueValid = 1'b0; RS = 4'd4; #1;
    checkVal("busy_rs4", busyRsA, 1);
    checkVal("cnt_1", cntA, 1);
    WbValid = 1'b1; WbAddr = 4'd4; WbData = 24'hABCDEF; #1;
    checkVal("busy_rs4_clr", busyRsA, 0);
    checkVal("wb_bypass_a", rsA, 24'hABCDEF);
    checkVal("wb_nobyp_b", rsB, 0);
    step();
    WbValid = 1'b0; #1;
    checkVal("wb_stored_b", rsB, 24'hABCDEF);
    checkVal("cnt_0", cntA, 0);

    // 4. Issue to busy register stalls; issue+clear same address; A/B collision
    IssueValid = 1'b1; IssueRD = 4'd5; step();
    #1;
    checkVal("iss5_stall", stallA, 1);
    step();
    checkVal("iss5_cnt", cntA, 1);
    WbValid = 1'b1; WbAddr = 4'd5; WbData = 24'h55; #1;
    checkVal("iss_clr_stall", stallB, 1);
    step();
    IssueValid = 1'b0; WbValid = 1'b0; #1;
    checkVal("iss_clr_cnt", cntA, 0);
    RS = 4'd6; RegWrite = 1'b1; RD = 4'd6; WriteData = 24'd11;
    WbValid = 1'b1; WbAddr = 4'd6; WbData = 24'd22; #1;
    checkVal("ab_bypass_a", rsA, 11);
    step();
    RegWrite = 1'b0; WbValid = 1'b0; #1;
    checkVal("ab_r6_a", rsA, 11);
    checkVal("ab_r6_b", rsB, 11);

    // Port A write to busy register keeps busy
    IssueValid = 1'b1; IssueRD = 4'd7; step();
    IssueValid = 1'b0; RegWrite = 1'b1; RD = 4'd7; WriteData = 24'h77; step();
    RegWrite = 1'b0; RT = 4'd7; #1;
    checkVal("abusy_cnt", cntB, 1);
    checkVal("abusy_rt", busyRtB, 1);
    checkVal("abusy_data", rtB, 24'h77);
    WbValid = 1'b1; WbAddr = 4'd7; WbData = 24'h78; step();
    WbValid = 1'b0; #1;
    checkVal("r7_wb", rtB, 24'h78);
    checkVal("r7_cnt", cntB, 0);

    // 5. Zero register
    RS = 4'd0; RD = 4'd0; WriteData = 24'h123; RegWrite = 1'b1;
    IssueValid = 1'b1; IssueRD = 4'd0; #1;
    checkVal("z_rs_a", rsA, 0);
    checkVal("z_stall", stallA, 0);
    step();
    RegWrite = 1'b0; IssueValid = 1'b0; #1;
    checkVal("z_rs_b", rsB, 0);
    checkVal("z_cnt", cntA, 0);
    IssueValid = 1'b1; #1;
    checkVal("z_stall2", stallA, 0);
    IssueValid = 1'b0;

    // 6. Busy R1..R3 then Flush (with a competing issue to R8)
    IssueValid = 1'b1;
    IssueRD = 4'd1; step();
    IssueRD = 4'd2; step();
    IssueRD = 4'd3; step();
    IssueValid = 1'b0; #1;
    checkVal("three_busy", cntA, 3);
    Flush = 1'b1; IssueValid = 1'b1; IssueRD = 4'd8; step();
    Flush = 1'b0; IssueValid = 1'b0; RS = 4'd1; #1;
    checkVal("flush_cnt", cntA, 0);
    checkVal("flush_rs1", busyRsA, 0);
    IssueValid = 1'b1; IssueRD = 4'd8; #1;
    checkVal("flush_no8", stallA, 0);
    step();
    IssueValid = 1'b0; RS = 4'd2; RT = 4'd3; #1;
    checkVal("pre_rst_cnt", cntA, 1);
    checkVal("pre_rst_r2", rsA, 9);

    // Asynchronous reset mid-cycle, then an in-flight port B write
    Reset_n = 1'b0; #1;
    checkVal("arst_rs", rsA, 0);
    checkVal("arst_rt", rtB, 0);
    checkVal("arst_cnt", cntA, 0);
    Reset_n = 1'b1;
    WbValid = 1'b1; WbAddr = 4'd3; WbData = 24'h333; step();
    WbValid = 1'b0; #1;
    checkVal("post_rst_wb", rtB, 24'h333);
    checkVal("post_rst_cnt", cntB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
